// File: rtl/rom_word_packer_if.sv
// Handshake/bus bundle for rom_word_packer: payload input side, flagged-word output side.
interface rom_word_packer_if #(
  parameter int N     = 9,
  parameter int DEPTH = 4
);
  logic [N-2:0]               in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       out_en;
  logic [N-1:0]               out_word;
  logic [$clog2(DEPTH):0]     level;

  modport master (
    output in_data, in_valid, out_en,
    input  in_ready, out_word, level
  );

  modport slave (
    input  in_data, in_valid, out_en,
    output in_ready, out_word, level
  );
endinterface

// File: rtl/rom_word_packer.sv
// Flagged-word packer: queues (N-1)-bit payloads in a small FIFO and emits {payload, flag}
// words on each out_en strobe; flag=1 with zero payload marks an idle word.
module rom_word_packer #(
  parameter int N     = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rom_word_packer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [N-1:0] IDLE = {{(N-1){1'b0}}, 1'b1};

  logic [N-2:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [N-1:0]  out_word_q, out_word_d;
  logic          full, empty, push, pop;

  // Status comes from registered level only, so in_ready has no path from out_en/in_valid.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_en & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    out_word_d = out_word_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A push into an empty FIFO is not visible to the same edge's pop.
    if (bus.out_en) out_word_d = pop ? {mem_q[rd_ptr_q], 1'b0} : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_word_q <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_word_q <= out_word_d;
    end
  end

  // Storage needs no reset; level/pointers alone define what is queued.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready = ~full;
  assign bus.out_word = out_word_q;
  assign bus.level    = level_q;

endmodule

// File: tb/tb_rom_word_packer.sv
// Directed bench for rom_word_packer: idle output, FIFO ordering, full/back-pressure,
// wrap with steady level, hold, and asynchronous reset mid-stream.
module tb_rom_word_packer;

  localparam int N     = 9;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rom_word_packer_if #(.N(N), .DEPTH(DEPTH)) bus ();

  rom_word_packer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_en   = 1'b0;
    #12;
    chk("rst_word",  32'(bus.out_word), 32'h001);
    chk("rst_level", 32'(bus.level),    32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: idle stream
    bus.out_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_idle",  32'(bus.out_word), 32'h001);
      chk("t1_level", 32'(bus.level),    32'd0);
      chk("t1_ready", 32'(bus.in_ready), 32'd1);
    end

    // 2: single payload
    bus.out_en = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    tick();
    chk("t2_level1", 32'(bus.level), 32'd1);
    bus.in_valid = 1'b0; bus.out_en = 1'b1;
    tick();
    chk("t2_word",   32'(bus.out_word), 32'h14A);
    chk("t2_level0", 32'(bus.level),    32'd0);
    tick();
    chk("t2_idle",   32'(bus.out_word), 32'h001);

    // 3: fill to full, fifth payload held by source
    bus.out_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      tick();
      chk("t3_level", 32'(bus.level),    (i < 4) ? 32'(i) : 32'd4);
      chk("t3_ready", 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    bus.out_en = 1'b1;
    tick();
    chk("t3_w1", 32'(bus.out_word), 32'h002);
    chk("t3_l1", 32'(bus.level),    32'd3);
    tick();
    chk("t3_w2", 32'(bus.out_word), 32'h004);
    chk("t3_l2", 32'(bus.level),    32'd3);
    bus.in_valid = 1'b0;
    tick();
    chk("t3_w3", 32'(bus.out_word), 32'h006);
    tick();
    chk("t3_w4", 32'(bus.out_word), 32'h008);
    tick();
    chk("t3_w5", 32'(bus.out_word), 32'h00A);
    chk("t3_l5", 32'(bus.level),    32'd0);

    // 4: steady level 2 through pointer wrap, then a zero payload
    bus.out_en = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 8'h10; tick();
    bus.in_data = 8'h11; tick();
    chk("t4_prefill", 32'(bus.level), 32'd2);
    bus.out_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.in_data = 8'(8'h12 + j);
      tick();
      chk("t4_word",  32'(bus.out_word), 32'({8'(8'h10 + j), 1'b0}));
      chk("t4_level", 32'(bus.level),    32'd2);
    end
    bus.in_data = 8'h00;
    tick();
    chk("t4_w1A", 32'(bus.out_word), 32'h034);
    bus.in_valid = 1'b0;
    tick();
    chk("t4_w1B", 32'(bus.out_word), 32'h036);
    tick();
    chk("t4_zero",  32'(bus.out_word), 32'h000);
    chk("t4_empty", 32'(bus.level),    32'd0);

    // 5: hold with out_en low
    bus.out_en = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h30;
    tick();
    bus.in_valid = 1'b0; bus.out_en = 1'b1;
    tick();
    chk("t5_w30", 32'(bus.out_word), 32'h060);
    bus.out_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.in_data  = 8'(8'h31 + k / 2);
      tick();
      chk("t5_hold",  32'(bus.out_word), 32'h060);
      chk("t5_level", 32'(bus.level),    32'(k / 2 + 1));
    end
    bus.in_valid = 1'b1; bus.in_data = 8'h33;
    tick();
    chk("t5_level3", 32'(bus.level), 32'd3);
    bus.in_valid = 1'b0;

    // 6: asynchronous reset mid-cycle at level 3
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_word",  32'(bus.out_word), 32'h001);
    chk("t6_level", 32'(bus.level),    32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd1);
    tick();
    #2;
    rst_n = 1'b1;
    bus.out_en = 1'b1;
    tick();
    chk("t6_post_idle",  32'(bus.out_word), 32'h001);
    chk("t6_post_level", 32'(bus.level),    32'd0);
    tick();
    chk("t6_post_idle2", 32'(bus.out_word), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
